// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//
// Bundles every signal exchanged between the ID/EX operand-select stage and
// the pipeline around it. The ID-side fields, stall/flush controls and the
// MEM/WB result buses flow into the stage. The EX-side operands, control bits
// and load-use request flow out of it.
//
// Modports:
//   master - pipeline side: drives id_*, stall_in, flush_in, mem_*, wb_*;
//            observes ex_* and load_use_stall.
//   slave  - id_ex_stage itself: the mirror image of master.
//
// Parameter:
//   XLEN - datapath width (default 32).
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  // ID-side decoded instruction
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [4:0]      id_rd_addr;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [3:0]      id_alu_sel;
  logic            id_a_sel_pc;
  logic            id_b_sel_imm;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;

  // Pipeline control
  logic            stall_in;
  logic            flush_in;

  // Results of the instructions further down the pipe
  logic            mem_fwd_valid;
  logic [4:0]      mem_rd_addr;
  logic [XLEN-1:0] mem_rd_data;
  logic            wb_fwd_valid;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;

  // EX-side outputs
  logic            ex_valid;
  logic [XLEN-1:0] ex_src_a;
  logic [XLEN-1:0] ex_src_b;
  logic [3:0]      ex_alu_sel;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
           id_alu_sel, id_a_sel_pc, id_b_sel_imm,
           id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush_in,
           mem_fwd_valid, mem_rd_addr, mem_rd_data,
           wb_fwd_valid, wb_rd_addr, wb_rd_data,
    input  ex_valid, ex_src_a, ex_src_b, ex_alu_sel, ex_store_data,
           ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
           id_alu_sel, id_a_sel_pc, id_b_sel_imm,
           id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush_in,
           mem_fwd_valid, mem_rd_addr, mem_rd_data,
           wb_fwd_valid, wb_rd_addr, wb_rd_data,
    output ex_valid, ex_src_a, ex_src_b, ex_alu_sel, ex_store_data,
           ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and ALU operand select for the 5-stage RV32I core.
// Captures the decoded instruction from ID, resolves RAW hazards by
// forwarding MEM/WB results onto the ALU operands, and requests a one-cycle
// bubble when an instruction in ID consumes the result of a load sitting in EX.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset, clears all registered state
//   bus   - id_ex_stage_if.slave: ID fields, stall/flush, MEM/WB result
//           buses in; EX operands/control and load_use_stall out
//
// Build option:
//   ID_EX_FWD_EN - when defined, enables the WB bypass on capture, MEM/WB
//                  output forwarding and load-use detection. When undefined,
//                  the *_fwd_* buses are ignored, operands come straight from
//                  the register and load_use_stall is tied low; software must
//                  schedule around hazards.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  // Registered EX state
  logic            valid_q,     valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [4:0]      rs1_addr_q,  rs1_addr_d;
  logic [4:0]      rs2_addr_q,  rs2_addr_d;
  logic [4:0]      rd_addr_q,   rd_addr_d;
  logic [3:0]      alu_sel_q,   alu_sel_d;
  logic            a_sel_pc_q,  a_sel_pc_d;
  logic            b_sel_imm_q, b_sel_imm_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;

  // Hazard resolution results
  logic [XLEN-1:0] cap_rs1_data;
  logic [XLEN-1:0] cap_rs2_data;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            load_use;

`ifdef ID_EX_FWD_EN
  // A producer matches a source register only if it really writes a
  // register, and never for x0 (hardwired zero must not be overridden).
  function automatic logic fwd_hit(input logic       prod_valid,
                                   input logic [4:0] prod_rd,
                                   input logic [4:0] src_addr);
    fwd_hit = prod_valid && (prod_rd != 5'd0) && (prod_rd == src_addr);
  endfunction

  // The register file is not write-through, so a WB write landing in the
  // same cycle as the ID read leaves stale data on id_rsN_data. Patch it
  // on the way into the pipeline register.
  always_comb begin
    cap_rs1_data = bus.id_rs1_data;
    cap_rs2_data = bus.id_rs2_data;
    if (fwd_hit(bus.wb_fwd_valid, bus.wb_rd_addr, bus.id_rs1_addr)) begin
      cap_rs1_data = bus.wb_rd_data;
    end
    if (fwd_hit(bus.wb_fwd_valid, bus.wb_rd_addr, bus.id_rs2_addr)) begin
      cap_rs2_data = bus.wb_rd_data;
    end
  end

  // Output forwarding: MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (fwd_hit(bus.mem_fwd_valid, bus.mem_rd_addr, rs1_addr_q)) begin
      fwd_rs1 = bus.mem_rd_data;
    end else if (fwd_hit(bus.wb_fwd_valid, bus.wb_rd_addr, rs1_addr_q)) begin
      fwd_rs1 = bus.wb_rd_data;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (fwd_hit(bus.mem_fwd_valid, bus.mem_rd_addr, rs2_addr_q)) begin
      fwd_rs2 = bus.mem_rd_data;
    end else if (fwd_hit(bus.wb_fwd_valid, bus.wb_rd_addr, rs2_addr_q)) begin
      fwd_rs2 = bus.wb_rd_data;
    end
  end

  // Load data is only available once the load reaches MEM, so a consumer
  // directly behind it must wait one cycle. While stalled or flushed the
  // bubble request is meaningless (EX holds or is being killed anyway).
  always_comb begin
    load_use = 1'b0;
    if (valid_q && mem_read_q && (rd_addr_q != 5'd0) && bus.id_valid &&
        !bus.stall_in && !bus.flush_in) begin
      load_use = (bus.id_use_rs1 && (bus.id_rs1_addr == rd_addr_q)) ||
                 (bus.id_use_rs2 && (bus.id_rs2_addr == rd_addr_q));
    end
  end
`else
  assign cap_rs1_data = bus.id_rs1_data;
  assign cap_rs2_data = bus.id_rs2_data;
  assign fwd_rs1      = rs1_data_q;
  assign fwd_rs2      = rs2_data_q;
  assign load_use     = 1'b0;

  // Hazard-related inputs have no function in this build.
  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_fwd_valid, bus.mem_rd_addr, bus.mem_rd_data,
                        bus.wb_fwd_valid, bus.wb_rd_addr, bus.wb_rd_data,
                        bus.id_use_rs1, bus.id_use_rs2};
`endif

  // Next-state selection: flush > stall > load-use bubble > capture.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_sel_d   = alu_sel_q;
    a_sel_pc_d  = a_sel_pc_q;
    b_sel_imm_d = b_sel_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    if (bus.flush_in || (!bus.stall_in && load_use)) begin
      // Bubble: side-effecting control bits must be clear so a dead slot
      // can never write the register file or memory.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!bus.stall_in) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_data_d  = cap_rs1_data;
      rs2_data_d  = cap_rs2_data;
      imm_d       = bus.id_imm;
      rs1_addr_d  = bus.id_rs1_addr;
      rs2_addr_d  = bus.id_rs2_addr;
      rd_addr_d   = bus.id_rd_addr;
      alu_sel_d   = bus.id_alu_sel;
      a_sel_pc_d  = bus.id_a_sel_pc;
      b_sel_imm_d = bus.id_b_sel_imm;
      reg_write_d = bus.id_valid & bus.id_reg_write;
      mem_read_d  = bus.id_valid & bus.id_mem_read;
      mem_write_d = bus.id_valid & bus.id_mem_write;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_sel_q   <= '0;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_sel_q   <= alu_sel_d;
      a_sel_pc_q  <= a_sel_pc_d;
      b_sel_imm_q <= b_sel_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // EX-side outputs
  assign bus.ex_valid       = valid_q;
  assign bus.ex_src_a       = a_sel_pc_q  ? pc_q  : fwd_rs1;
  assign bus.ex_src_b       = b_sel_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.ex_alu_sel     = alu_sel_q;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_rd_addr     = rd_addr_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_mem_write   = mem_write_q;
  assign bus.load_use_stall = load_use;

endmodule
